e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//  Multiply/divide unit for the Execute stage. Runs alongside the ALU and feeds EX/MEM through the
//  E-stage result mux (MFHI/MFLO read data). Owns the architectural HI/LO registers.
//  Models multi-cycle MULT/DIV latency with a busy counter; exports an occupancy flag the hazard
//  unit uses to stall D-stage MDU instructions.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high; clears all state immediately
//  start        in   1   E-stage instr is a valid MDU op this cycle (low on bubble/flush)
//  mdu_op       in   4   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO; 9-15 = NONE
//  E_A          in   32  rs operand (forwarded)
//  E_B          in   32  rt operand (forwarded)
//  busy         out  1   registered; high while a MULT/DIV is in flight
//  md_occupied  out  1   comb: busy | (start & mdu_op in 1..4)
//  HI, LO       out  32  registered architectural HI/LO
//  E_mdu_out    out  32  comb: mdu_op==MFHI ? HI : mdu_op==MFLO ? LO : 0
// BEHAVIOUR
//  Reset (async): busy=0, HI=0, LO=0, counter=0, pending results=0. Reset mid-operation
//   discards the in-flight result; HI/LO stay 0 after release.
//  Accept: op is acted on only at an edge where start=1 and busy=0. While busy=1, every op
//   (incl. MTHI/MTLO) is ignored; the hazard unit guarantees none arrive.
//  MULT/MULTU/DIV/DIVU accepted at edge T: result computed from E_A/E_B at T into pending
//   regs; counter<=N-1 (N=MULT_CYCLES or DIV_CYCLES); busy<=1.
//   Each later edge: counter decrements. At edge T+N: HI/LO<=pending, busy<=0.
//   busy is therefore high for exactly N cycles; new results become visible in the cycle after
//   busy falls. A new op may be accepted at edge T+N+1 at the earliest.
//  MULT: {HI,LO}=signed 64-bit A*B. MULTU: unsigned 64-bit product.
//  DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
//   0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (no trap).
//  DIVU: unsigned quotient/remainder.
//  Divide by zero (B==0): busy still runs DIV_CYCLES; HI/LO unchanged at completion.
//  MTHI/MTLO accepted at edge T: HI (LO) <= E_A at T; busy unaffected; other register kept.
//  MFHI/MFLO: no state change. E_mdu_out shows current HI/LO, i.e. values before any write at
//   the same edge. No bypass of pending results.
//  start=0 or op NONE: no state change. Counter and pending regs are internal only.
// TESTING
//  1 reset mid-op: MULT 3*4, assert reset 2 cycles later -> busy=0, HI=LO=0 at once; later MFLO -> 0.
//  2 MULT 0xFFFFFFFF*2 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//    MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
//  3 DIV -7/2 -> busy exactly 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
//    DIVU 7/2 -> LO=3, HI=1.
//  4 DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//    DIV 5/0 after MTHI 0x11, MTLO 0x22 -> busy 10 cycles, HI=0x11, LO=0x22.
//  5 MTLO 0xABCD with start=1 while busy -> ignored, LO=product on completion.
//    md_occupied=1 in the start cycle of any MULT/DIV.
//  6 MTHI 0x5 then MFHI next cycle -> E_mdu_out=0x5.
//    mdu_op=12 with start=1 -> no change; E_mdu_out=0.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO and models MULT/DIV latency
// with a busy counter so the hazard unit can stall later MDU instructions.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        busy,
  output logic        md_occupied,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_mdu_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_wr;

  logic        is_md;
  logic        is_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic        div_zero;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo;
  logic [31:0] rem;

  assign is_md     = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                     (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
  assign is_signed = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);

  // Handshake: an op is taken only at an edge with start=1 and busy=0;
  // anything presented while busy=1 is dropped, never queued.
  assign md_occupied = busy | (start & is_md);

  // One 64-bit multiplier serves both signednesses via conditional sign extension.
  assign mul_a = {{32{is_signed & E_A[31]}}, E_A};
  assign mul_b = {{32{is_signed & E_B[31]}}, E_B};
  assign prod  = mul_a * mul_b;

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign a_neg    = is_signed & E_A[31];
  assign b_neg    = is_signed & E_B[31];
  assign div_zero = (E_B == 32'd0);
  assign dvd      = a_neg ? -E_A : E_A;
  assign dvs      = div_zero ? 32'd1 : (b_neg ? -E_B : E_B);
  assign quo_u    = dvd / dvs;
  assign rem_u    = dvd % dvs;
  assign quo      = (a_neg ^ b_neg) ? -quo_u : quo_u;
  assign rem      = a_neg ? -rem_u : rem_u;

  always_comb begin
    E_mdu_out = 32'd0;
    if (mdu_op == OP_MFHI)      E_mdu_out = HI;
    else if (mdu_op == OP_MFLO) E_mdu_out = LO;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
        if (pend_wr) begin
          HI <= pend_hi;
          LO <= pend_lo;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (start) begin
      case (mdu_op)
        OP_MULT, OP_MULTU: begin
          pend_hi <= prod[63:32];
          pend_lo <= prod[31:0];
          pend_wr <= 1'b1;
          cnt     <= MULT_LAST;
          busy    <= 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          pend_hi <= rem;
          pend_lo <= quo;
          pend_wr <= ~div_zero;
          cnt     <= DIV_LAST;
          busy    <= 1'b1;
        end
        OP_MTHI: HI <= E_A;
        OP_MTLO: LO <= E_A;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases plus a short random run,
// with completed HI/LO results checked against a queue of expected values.
module tb_e_mdu;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = OP_NONE;
  logic [31:0] E_A = 32'd0;
  logic [31:0] E_B = 32'd0;
  logic        busy;
  logic        md_occupied;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_mdu_out;

  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .E_A(E_A), .E_B(E_B), .busy(busy), .md_occupied(md_occupied),
    .HI(HI), .LO(LO), .E_mdu_out(E_mdu_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int q;
    int r;
    logic [63:0] u;
    case (op)
      OP_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      OP_MULTU: begin
        u = {32'd0, a} * {32'd0, b};
        return u;
      end
      OP_DIV: begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  // ---------------- drivers (enter and leave just after a negedge) ----------------
  task automatic idle();
    start  = 1'b0;
    mdu_op = OP_NONE;
  endtask

  task automatic simple_op(input logic [3:0] op, input logic [31:0] a);
    start = 1'b1; mdu_op = op; E_A = a;
    @(posedge clk); @(negedge clk);
    idle();
  endtask

  // Issues a MULT/DIV, measures busy length, then checks HI/LO against the queue.
  task automatic md_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int n, input logic [63:0] exp,
                       input bit inject_mtlo);
    int cycles;
    logic [63:0] want;
    exp_q.push_back(exp);
    start = 1'b1; mdu_op = op; E_A = a; E_B = b;
    #1 check_eq({tag, "_occ"}, 64'(md_occupied), 64'd1);
    @(posedge clk); @(negedge clk);
    idle();
    if (inject_mtlo) begin
      start = 1'b1; mdu_op = OP_MTLO; E_A = 32'hABCD;
    end
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
      idle();
    end
    check_eq({tag, "_busy_len"}, 64'(cycles), 64'(n));
    want = exp_q.pop_front();
    check_eq({tag, "_hilo"}, {HI, LO}, want);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int n;

    @(negedge clk); @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_hilo", {HI, LO}, 64'd0);
    check_eq("rst_out", 64'(E_mdu_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of a MULT discards it.
    simple_op(OP_MTLO, 32'h99);
    check_eq("mtlo_pre", 64'(LO), 64'h99);
    start = 1'b1; mdu_op = OP_MULT; E_A = 32'd3; E_B = 32'd4;
    @(posedge clk); @(negedge clk);
    idle();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("postrst_hilo", {HI, LO}, 64'd0);
    start = 1'b1; mdu_op = OP_MFLO;
    #1 check_eq("postrst_mflo", 64'(E_mdu_out), 64'd0);
    @(posedge clk); @(negedge clk);
    idle();

    md_op("mult",  OP_MULT,  32'hFFFFFFFF, 32'd2, 5, {32'hFFFFFFFF, 32'hFFFFFFFE}, 1'b0);
    md_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, {32'h00000001, 32'hFFFFFFFE}, 1'b0);
    md_op("div",   OP_DIV,   32'hFFFFFFF9, 32'd2, 10, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
    md_op("divu",  OP_DIVU,  32'd7, 32'd2, 10, {32'd1, 32'd3}, 1'b0);
    md_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, {32'd0, 32'h80000000}, 1'b0);

    simple_op(OP_MTHI, 32'h11);
    simple_op(OP_MTLO, 32'h22);
    check_eq("mt_hilo", {HI, LO}, {32'h11, 32'h22});
    md_op("div0", OP_DIV, 32'd5, 32'd0, 10, {32'h11, 32'h22}, 1'b0);

    md_op("mult_inj", OP_MULT, 32'd6, 32'd7, 5, {32'd0, 32'd42}, 1'b1);

    simple_op(OP_MTHI, 32'h5);
    start = 1'b1; mdu_op = OP_MFHI;
    #1 check_eq("mfhi", 64'(E_mdu_out), 64'h5);
    @(posedge clk); @(negedge clk);
    idle();

    start = 1'b1; mdu_op = 4'd12; E_A = 32'hDEAD; E_B = 32'hBEEF;
    #1 check_eq("op12_out", 64'(E_mdu_out), 64'd0);
    check_eq("op12_occ", 64'(md_occupied), 64'd0);
    @(posedge clk); @(negedge clk);
    idle();
    check_eq("op12_hilo", {HI, LO}, {32'h5, 32'd42});
    check_eq("op12_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom();
      b  = $urandom();
      if (b == 32'd0) b = 32'd1;
      if (op == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      n  = (op <= OP_MULTU) ? 5 : 10;
      md_op($sformatf("rnd%0d", i), op, a, b, n, model(op, a, b), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
